// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file access controller.
// Optional build macro: REGFILE_ACCESS_SKIP_EN (skips regfile reads whose
// result is already known: x0 operands and a repeated rs2 address).
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int ADDR_W     = 5;
  localparam int RF_REGNO_W = 6;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [XLEN-1:0]   rf_data_t;

  localparam rf_addr_t               ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam rf_data_t               DATA_ZERO  = {XLEN{1'b0}};
  localparam logic [RF_REGNO_W-1:0]  REGNO_ZERO = {RF_REGNO_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ1 = 3'd1,
    READ2 = 3'd2,
    RESP  = 3'd3,
    WRITE = 3'd4
  } rf_ctrl_state_e;

  // Architectural address zero-extended onto the wider regfile regno pin.
  function automatic logic [RF_REGNO_W-1:0] zext_regno(input rf_addr_t addr);
    return {{(RF_REGNO_W-ADDR_W){1'b0}}, addr};
  endfunction

  // A second regfile read is only informative when rs2 is neither x0 nor a
  // repeat of rs1 (whose value is captured by the first read).
  function automatic logic rd2_needed(input rf_addr_t a1, input rf_addr_t a2);
    return (a2 != ADDR_ZERO) && (a2 != a1);
  endfunction

endpackage

// File: rtl/regfile_access_ctrl.sv
// Serialises decode read-pair requests and writeback requests onto the
// single-ported regfile, one register per cycle, and returns the captured
// read pair with a valid/ready handshake.
// Optional build macro: REGFILE_ACCESS_SKIP_EN. When defined, reads of x0 and
// a repeated rs2 are skipped (latency 1..3); otherwise latency is always 3.
module regfile_access_ctrl
  import regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic [ADDR_W-1:0]      rs1_addr,
  input  logic [ADDR_W-1:0]      rs2_addr,
  output logic                   rd_rsp_valid,
  input  logic                   rd_rsp_ready,
  output logic [XLEN-1:0]        rs1_data,
  output logic [XLEN-1:0]        rs2_data,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  output logic [RF_REGNO_W-1:0]  rf_regno,
  output logic                   rf_write,
  output logic [XLEN-1:0]        rf_wdata,
  input  logic [XLEN-1:0]        rf_rdata
);

  rf_ctrl_state_e r_state;
  rf_ctrl_state_e w_state_nxt;

  logic     r_last_grant_wb;
  logic     w_grant_wb;
  logic     w_grant_rd;

  rf_addr_t r_rs1_addr;
  rf_addr_t r_rs2_addr;
  rf_addr_t r_wb_addr;
  rf_data_t r_wb_data;
  rf_data_t r_rs1_q;
  rf_data_t r_rs2_q;
  logic     r_rf_write;

  rf_addr_t w_rd_addr;
  rf_data_t w_rd_capture;

  // Read-skip decisions: at acceptance (from the request inputs) and in
  // READ1 (from the latched addresses).
  logic     w_need_rd1_req;
  logic     w_need_rd2_req;
  logic     w_need_rd2_q;
  logic     w_copy_rs2;

`ifdef REGFILE_ACCESS_SKIP_EN
  assign w_need_rd1_req = (rs1_addr != ADDR_ZERO);
  assign w_need_rd2_req = rd2_needed(rs1_addr, rs2_addr);
  assign w_need_rd2_q   = rd2_needed(r_rs1_addr, r_rs2_addr);
  assign w_copy_rs2     = (r_rs2_addr == r_rs1_addr);
`else
  assign w_need_rd1_req = 1'b1;
  assign w_need_rd2_req = 1'b1;
  assign w_need_rd2_q   = 1'b1;
  assign w_copy_rs2     = 1'b0;
`endif

  // Arbitration in IDLE: sole requester wins; on a tie alternate using last grant.
  always_comb begin
    w_grant_wb = 1'b0;
    w_grant_rd = 1'b0;
    if (rst_n && (r_state == IDLE)) begin
      if (wb_valid && rd_req_valid) begin
        if (r_last_grant_wb) begin
          w_grant_rd = 1'b1;
        end else begin
          w_grant_wb = 1'b1;
        end
      end else if (wb_valid) begin
        w_grant_wb = 1'b1;
      end else if (rd_req_valid) begin
        w_grant_rd = 1'b1;
      end else begin
        w_grant_wb = 1'b0;
        w_grant_rd = 1'b0;
      end
    end else begin
      w_grant_wb = 1'b0;
      w_grant_rd = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_wb) begin
          w_state_nxt = WRITE;
        end else if (w_grant_rd) begin
          if (w_need_rd1_req) begin
            w_state_nxt = READ1;
          end else if (w_need_rd2_req) begin
            w_state_nxt = READ2;
          end else begin
            w_state_nxt = RESP;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      READ1: begin
        if (w_need_rd2_q) begin
          w_state_nxt = READ2;
        end else begin
          w_state_nxt = RESP;
        end
      end
      READ2: w_state_nxt = RESP;
      RESP: begin
        if (rd_rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Remember who won the last grant so ties alternate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant_wb <= 1'b0;
    end else if (w_grant_wb) begin
      r_last_grant_wb <= 1'b1;
    end else if (w_grant_rd) begin
      r_last_grant_wb <= 1'b0;
    end else begin
      r_last_grant_wb <= r_last_grant_wb;
    end
  end

  // Latch request fields on acceptance; requesters may change them afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_addr <= ADDR_ZERO;
      r_rs2_addr <= ADDR_ZERO;
      r_wb_addr  <= ADDR_ZERO;
      r_wb_data  <= DATA_ZERO;
    end else begin
      if (w_grant_rd) begin
        r_rs1_addr <= rs1_addr;
        r_rs2_addr <= rs2_addr;
      end else begin
        r_rs1_addr <= r_rs1_addr;
        r_rs2_addr <= r_rs2_addr;
      end
      if (w_grant_wb) begin
        r_wb_addr <= wb_addr;
        r_wb_data <= wb_data;
      end else begin
        r_wb_addr <= r_wb_addr;
        r_wb_data <= r_wb_data;
      end
    end
  end

  // Regfile write strobe as a flop: high for exactly the WRITE cycle, never for x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_write <= 1'b0;
    end else begin
      r_rf_write <= w_grant_wb && (wb_addr != ADDR_ZERO);
    end
  end

  // Value to capture this cycle; x0 always reads as zero whatever the regfile drives.
  always_comb begin
    if (r_state == READ2) begin
      w_rd_addr = r_rs2_addr;
    end else begin
      w_rd_addr = r_rs1_addr;
    end
    if (w_rd_addr == ADDR_ZERO) begin
      w_rd_capture = DATA_ZERO;
    end else begin
      w_rd_capture = rf_rdata;
    end
  end

  // Holding registers: cleared on read acceptance so skipped reads yield zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_q <= DATA_ZERO;
      r_rs2_q <= DATA_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_rd) begin
            r_rs1_q <= DATA_ZERO;
            r_rs2_q <= DATA_ZERO;
          end else begin
            r_rs1_q <= r_rs1_q;
            r_rs2_q <= r_rs2_q;
          end
        end
        READ1: begin
          r_rs1_q <= w_rd_capture;
          if (w_copy_rs2) begin
            r_rs2_q <= w_rd_capture;
          end else begin
            r_rs2_q <= r_rs2_q;
          end
        end
        READ2: begin
          r_rs1_q <= r_rs1_q;
          r_rs2_q <= w_rd_capture;
        end
        default: begin
          r_rs1_q <= r_rs1_q;
          r_rs2_q <= r_rs2_q;
        end
      endcase
    end
  end

  // Regfile address/data pins decoded from state; zero outside access states.
  always_comb begin
    rf_regno = REGNO_ZERO;
    rf_wdata = DATA_ZERO;
    case (r_state)
      READ1: rf_regno = zext_regno(r_rs1_addr);
      READ2: rf_regno = zext_regno(r_rs2_addr);
      WRITE: begin
        rf_regno = zext_regno(r_wb_addr);
        rf_wdata = r_wb_data;
      end
      default: begin
        rf_regno = REGNO_ZERO;
        rf_wdata = DATA_ZERO;
      end
    endcase
  end

  assign rf_write     = r_rf_write;
  assign rd_req_ready = w_grant_rd;
  assign wb_ready     = w_grant_wb;
  assign rd_rsp_valid = (r_state == RESP);
  assign rs1_data     = r_rs1_q;
  assign rs2_data     = r_rs2_q;

endmodule
